// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control-FSM decisions, instruction-memory read port and the
// fetched instruction presented downstream. master = fetch stage, slave = its environment.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 128
);
  logic                   instr_ptr_en;
  logic [1:0]             instr_ptr_load_en;
  logic                   alu_cmp_bit;
  logic [INSTR_WIDTH-1:0] mem_rd_data;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd_en;
  logic [INSTR_WIDTH-1:0] instr_word;
  logic [7:0]             opcode;
  logic                   instr_valid;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   fetch_err;

  modport master (
    input  instr_ptr_en, instr_ptr_load_en, alu_cmp_bit, mem_rd_data,
    output mem_addr, mem_rd_en, instr_word, opcode, instr_valid, pc, fetch_err
  );

  modport slave (
    output instr_ptr_en, instr_ptr_load_en, alu_cmp_bit, mem_rd_data,
    input  mem_addr, mem_rd_en, instr_word, opcode, instr_valid, pc, fetch_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and fetch stage feeding the control FSM; masks the opcode to NOP while a read is in flight.
// Optional macro FETCH_BOUNDS_CHECK_EN parks the fetcher with a sticky fetch_err on a next pc >= PROG_DEPTH.
module instr_fetch #(
  parameter int ADDR_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 128,
  parameter int JUMP_ADDR_LSB  = 40,
  parameter int MEM_RD_LATENCY = 1,
  parameter int PROG_DEPTH     = 65536
) (
  input  logic            clk,
  input  logic            reset,
  instr_fetch_if.master   bus
);

  localparam logic [2:0] LATENCY = 3'(MEM_RD_LATENCY);

  if (MEM_RD_LATENCY < 1 || MEM_RD_LATENCY > 4 || PROG_DEPTH < 1) begin : g_bad_params
    $error("instr_fetch: MEM_RD_LATENCY must be 1..4 and PROG_DEPTH positive");
  end

  typedef enum logic {
    FETCH_WAIT,
    READY
  } state_t;

  state_t                  state;
  logic [2:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [INSTR_WIDTH-1:0]  word_q;
  logic                    valid_q;
  logic                    rd_en_q;
  logic                    err_q;
  logic                    take_jump;
  logic [ADDR_WIDTH-1:0]   jump_target;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic                    out_of_range;
  logic                    advance;

  assign jump_target = word_q[JUMP_ADDR_LSB +: ADDR_WIDTH];
  assign take_jump   = (bus.instr_ptr_load_en == 2'd1) ||
                       (bus.instr_ptr_load_en == 2'd2 && bus.alu_cmp_bit);
  assign next_pc     = take_jump ? jump_target : pc_q + 1'b1;
  assign advance     = (state == READY) && bus.instr_ptr_en && !err_q;

`ifdef FETCH_BOUNDS_CHECK_EN
  // The increment is judged before wrapping so that all-ones + 1 counts as out of range.
  assign out_of_range = take_jump ? (32'(jump_target) >= 32'(PROG_DEPTH))
                                  : (32'(pc_q) + 32'd1 >= 32'(PROG_DEPTH));

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (advance && out_of_range)
      err_q <= 1'b1;
  end
`else
  assign out_of_range = 1'b0;
  assign err_q        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_WAIT;
      wait_cnt <= LATENCY;
      pc_q     <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      rd_en_q  <= 1'b1;
    end else begin
      case (state)
        FETCH_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            word_q  <= bus.mem_rd_data;
            valid_q <= 1'b1;
            rd_en_q <= 1'b0;
            state   <= READY;
          end
        end
        READY: begin
          // An out-of-range target leaves pc untouched and drops valid for good.
          if (advance && out_of_range) begin
            valid_q <= 1'b0;
          end else if (advance) begin
            pc_q     <= next_pc;
            valid_q  <= 1'b0;
            rd_en_q  <= 1'b1;
            wait_cnt <= LATENCY;
            state    <= FETCH_WAIT;
          end
        end
        default: state <= FETCH_WAIT;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.mem_addr    = pc_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.instr_word  = word_q;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = valid_q ? word_q[INSTR_WIDTH-1 -: 8] : 8'h00;
  assign bus.fetch_err   = err_q;

endmodule
